// File: rtl/ctrl_hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_hazard_sequencer_if
// Brief   : Hazard inputs, resolve report, fetch/pipeline controls and status
//           of the control-hazard sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface ctrl_hazard_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              bubble;
    logic              resolve_valid;
    logic              resolve_taken;
    logic [ADDR_W-1:0] resolve_target;
    logic              pc_write_en;
    logic              pc_redirect_sel;
    logic [ADDR_W-1:0] pc_redirect;
    logic              ifId_write_en;
    logic              ifId_flush;
    logic              idEx_bubble;
    logic              busy;
    logic              timeout_err;
    logic              proto_err;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  ctrl_stall_cnt;

    // Hazard unit / branch resolver / pipeline side
    modport master (
        output stall, bubble, resolve_valid, resolve_taken, resolve_target,
        input  pc_write_en, pc_redirect_sel, pc_redirect, ifId_write_en,
               ifId_flush, idEx_bubble, busy, timeout_err, proto_err,
               bubble_cnt, ctrl_stall_cnt
    );

    // Sequencer side
    modport slave (
        input  stall, bubble, resolve_valid, resolve_taken, resolve_target,
        output pc_write_en, pc_redirect_sel, pc_redirect, ifId_write_en,
               ifId_flush, idEx_bubble, busy, timeout_err, proto_err,
               bubble_cnt, ctrl_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_hazard_sequencer
// Brief   : Holds fetch across load-use and control hazards, then steers the PC
//           to the resolved target or the sequential path.
// Revision: 1.0 - initial release
// ============================================================================
module ctrl_hazard_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 7
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ctrl_hazard_sequencer_if.slave bus
);

    localparam logic [0:0]       c_RUN          = 1'b0;
    localparam logic [0:0]       c_CTRL_WAIT    = 1'b1;
    localparam logic [7:0]       c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_timeout_err;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_ctrl_stall_cnt;

    logic w_pc_write_en;
    logic w_pc_redirect_sel;
    logic w_ifid_write_en;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_bubble_inc;
    logic w_ctrl_inc;
    logic w_timeout_set;
    logic w_proto_set;

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_pc_write_en     = 1'b1;
        w_pc_redirect_sel = 1'b0;
        w_ifid_write_en   = 1'b1;
        w_ifid_flush      = 1'b0;
        w_idex_bubble     = 1'b0;
        w_bubble_inc      = 1'b0;
        w_ctrl_inc        = 1'b0;
        w_timeout_set     = 1'b0;
        w_proto_set       = 1'b0;

        case (r_state)
            c_RUN: begin
                w_proto_set = bus.resolve_valid;
                if (bus.bubble) begin
                    w_pc_write_en   = 1'b0;
                    w_ifid_write_en = 1'b0;
                    w_idex_bubble   = 1'b1;
                    w_bubble_inc    = 1'b1;
                end else if (bus.stall) begin
                    // Branch moves on to execute; fetch is held behind it
                    w_pc_write_en  = 1'b0;
                    w_ifid_flush   = 1'b1;
                    w_state_nxt    = c_CTRL_WAIT;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            c_CTRL_WAIT: begin
                w_ctrl_inc   = 1'b1;
                w_ifid_flush = 1'b1;
                if (bus.resolve_valid) begin
                    w_pc_redirect_sel = bus.resolve_taken;
                    w_state_nxt       = c_RUN;
                end else if (r_wait_cnt == c_TIMEOUT_LAST) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = c_RUN;
                end else begin
                    w_pc_write_en  = 1'b0;
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: w_state_nxt = c_RUN;
        endcase

        // While reset is held the pipeline free-runs regardless of hazards
        if (!rst_n) begin
            w_pc_write_en     = 1'b1;
            w_pc_redirect_sel = 1'b0;
            w_ifid_write_en   = 1'b1;
            w_ifid_flush      = 1'b0;
            w_idex_bubble     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_RUN;
            r_wait_cnt       <= 8'd0;
            r_timeout_err    <= 1'b0;
            r_proto_err      <= 1'b0;
            r_bubble_cnt     <= '0;
            r_ctrl_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout_set) r_timeout_err <= 1'b1;
            if (w_proto_set)   r_proto_err   <= 1'b1;
            if (w_bubble_inc && (r_bubble_cnt != c_CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (w_ctrl_inc && (r_ctrl_stall_cnt != c_CNT_MAX))
                r_ctrl_stall_cnt <= r_ctrl_stall_cnt + 1'b1;
        end
    end

    assign bus.pc_write_en     = w_pc_write_en;
    assign bus.pc_redirect_sel = w_pc_redirect_sel;
    assign bus.pc_redirect     = bus.resolve_target;
    assign bus.ifId_write_en   = w_ifid_write_en;
    assign bus.ifId_flush      = w_ifid_flush;
    assign bus.idEx_bubble     = w_idex_bubble;
    assign bus.busy            = (r_state == c_CTRL_WAIT);
    assign bus.timeout_err     = r_timeout_err;
    assign bus.proto_err       = r_proto_err;
    assign bus.bubble_cnt      = r_bubble_cnt;
    assign bus.ctrl_stall_cnt  = r_ctrl_stall_cnt;

endmodule
`default_nettype wire
